// File: rtl/pc_redirect_pkg.sv
// rtl/pc_redirect_pkg.sv - shared types and constants for the PC redirect sequencer
package pc_redirect_pkg;

    localparam int ADDR_W_DEF = 32;

    // Instruction alignment mask: clears the low two bits of a fetch address.
    localparam logic [31:0] IALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LOAD = 2'd2
    } rd_state_e;

endpackage

// File: rtl/redirect_hold_timer.sv
// rtl/redirect_hold_timer.sv - saturating HOLD-cycle counter with sticky timeout flag
//
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   count_en   in  count one HOLD cycle
//   clear      in  return the counter to zero (wins over count_en)
//   threshold  in  count value at which the timeout flag is set
//   timeout    out sticky flag, cleared only by reset
module redirect_hold_timer #(
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             clear,
    input  logic [TMO_W-1:0] threshold,
    output logic             timeout
);

    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] cnt_inc;

    // Saturate instead of wrapping so a stuck cache can never re-arm a small count.
    assign cnt_inc = (tmo_cnt == {TMO_W{1'b1}}) ? tmo_cnt : tmo_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (clear) begin
                tmo_cnt <= '0;
            end else if (count_en) begin
                tmo_cnt <= cnt_inc;
                // Flag rises on the same edge the counter reaches the threshold.
                if (cnt_inc >= threshold) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pc_redirect_sequencer.sv
// rtl/pc_redirect_sequencer.sv - captures EX redirects, squashes wrong path, loads fetch PC
//
// Optional feature macro: MISALIGN_TRAP_EN (misaligned targets trap instead of being aligned).
//
// Ports:
//   CLK              in   system clock, rising edge
//   RESET            in   asynchronous active-low reset
//   redirect_valid   in   branch taken / jump from EX
//   redirect_target  in   target PC with redirect_valid
//   ex_stall         in   EX frozen; redirect not accepted
//   icache_busy      in   fetch cannot take a new PC this cycle
//   pc_load          out  one-cycle load strobe for the PC register
//   pc_target        out  registered redirect target
//   flush_if_id      out  squash IF/ID
//   flush_id_ex      out  squash ID/EX
//   redirect_busy    out  sequencer not idle
//   hold_timeout     out  sticky: HOLD lasted HOLD_TIMEOUT cycles
//   misalign_trap    out  one-cycle pulse after a misaligned accept (macro builds only)
module pc_redirect_sequencer
    import pc_redirect_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int HOLD_TIMEOUT = 255,
    parameter int TMO_W        = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              ex_stall,
    input  logic              icache_busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect_busy,
    output logic              hold_timeout,
    output logic              misalign_trap
);

    // Widen the 32-bit mask by inverting the (zero-extended) complement, so upper bits stay set.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(~IALIGN_MASK));

    rd_state_e state, next_state;
    logic      accept;
    logic      hold_count;
    logic      hold_clear;

    // Gated by RESET so no combinational flush escapes while the block is held in reset.
    assign accept        = redirect_valid & ~ex_stall & (state == IDLE) & RESET;
    assign redirect_busy = (state != IDLE);
    assign hold_count    = (state == HOLD) & icache_busy;
    assign hold_clear    = (state == HOLD) & ~icache_busy;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        pc_load     = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    if (redirect_target[1:0] != 2'b00) begin
                        next_state = IDLE;
                    end else begin
                        next_state = icache_busy ? HOLD : LOAD;
                    end
`else
                    next_state = icache_busy ? HOLD : LOAD;
`endif
                end
            end
            HOLD: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (!icache_busy) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                // Issued even if the cache turns busy again; the PC register latches anyway.
                pc_load     = 1'b1;
                flush_if_id = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_target <= '0;
        end else if (accept) begin
`ifdef MISALIGN_TRAP_EN
            pc_target <= redirect_target;
`else
            pc_target <= redirect_target & ALIGN_MASK;
`endif
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept & (redirect_target[1:0] != 2'b00);
        end
    end
    assign misalign_trap = misalign_q;
`else
    assign misalign_trap = 1'b0;
`endif

    redirect_hold_timer #(
        .TMO_W(TMO_W)
    ) u_hold_timer (
        .clk       (CLK),
        .rst_n     (RESET),
        .count_en  (hold_count),
        .clear     (hold_clear),
        .threshold (TMO_W'(HOLD_TIMEOUT)),
        .timeout   (hold_timeout)
    );

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// tb/tb_pc_redirect_sequencer.sv - scoreboard testbench for pc_redirect_sequencer
module tb_pc_redirect_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        ex_stall = 1'b0;
    logic        icache_busy = 1'b0;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect_busy;
    logic        hold_timeout;
    logic        misalign_trap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n;

    int          exp_cyc[$];
    logic [31:0] exp_tgt[$];

    pc_redirect_sequencer #(
        .ADDR_W(32),
        .HOLD_TIMEOUT(4),
        .TMO_W(8)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ex_stall        (ex_stall),
        .icache_busy     (icache_busy),
        .pc_load         (pc_load),
        .pc_target       (pc_target),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .redirect_busy   (redirect_busy),
        .hold_timeout    (hold_timeout),
        .misalign_trap   (misalign_trap)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic chk_flush(input string name, input logic fi, input logic fe, input logic bz);
        chk({name, "_flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fi});
        chk({name, "_flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fe});
        chk({name, "_busy"}, {31'd0, redirect_busy}, {31'd0, bz});
    endtask

    task automatic expect_load(input int c, input logic [31:0] t);
        exp_cyc.push_back(c);
        exp_tgt.push_back(t);
    endtask

    // Monitor: every pc_load pulse must match the oldest scoreboard entry.
    always @(negedge CLK) begin
        if (pc_load === 1'b1) begin
            if (exp_cyc.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_pc_load: got pc_load=1 target 0x%0h expected no load (cycle %0d)", pc_target, cyc);
            end else begin
                chk("pc_load_cycle", cyc, exp_cyc.pop_front());
                chk("pc_load_target", pc_target, exp_tgt.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        sample();
        chk("rst_pc_target", pc_target, 32'h0);
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rst_timeout", {31'd0, hold_timeout}, 32'd0);
        chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
        chk_flush("rst", 1'b0, 1'b0, 1'b0);
        tick();
        RESET = 1'b1;
        tick();

        // 1: jump, cache free
        redirect_valid = 1'b1; redirect_target = 32'h0000_0100; icache_busy = 1'b0;
        n = cyc;
        expect_load(n + 1, 32'h100);
        sample();
        chk_flush("t1_accept", 1'b1, 1'b1, 1'b0);
        tick();
        redirect_valid = 1'b0;
        sample();
        chk_flush("t1_load", 1'b1, 1'b0, 1'b1);
        tick();
        sample();
        chk_flush("t1_idle", 1'b0, 1'b0, 1'b0);

        // 2: branch during miss; busy falls in the third HOLD cycle
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_2000; icache_busy = 1'b1;
        n = cyc;
        expect_load(n + 4, 32'h2000);
        sample();
        chk_flush("t2_accept", 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            redirect_valid = 1'b0;
            sample();
            chk_flush("t2_hold", 1'b1, 1'b1, 1'b1);
        end
        tick();
        icache_busy = 1'b0;
        sample();
        chk_flush("t2_hold_last", 1'b1, 1'b1, 1'b1);
        tick();
        sample();
        chk_flush("t2_load", 1'b1, 1'b0, 1'b1);
        tick();
        sample();
        chk("t2_no_timeout", {31'd0, hold_timeout}, 32'd0);

        // 3: stalled EX
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_3000; ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk_flush("t3_stalled", 1'b0, 1'b0, 1'b0);
            tick();
        end
        ex_stall = 1'b0;
        n = cyc;
        expect_load(n + 1, 32'h3000);
        sample();
        chk_flush("t3_accept", 1'b1, 1'b1, 1'b0);
        tick();
        redirect_valid = 1'b0;
        tick();

        // 4: HOLD timeout (threshold 4)
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_4000; icache_busy = 1'b1;
        n = cyc;
        for (int i = 1; i <= 4; i++) begin
            tick();
            redirect_valid = 1'b0;
            sample();
            chk("t4_pre_timeout", {31'd0, hold_timeout}, 32'd0);
        end
        tick();
        sample();
        chk("t4_timeout_set", {31'd0, hold_timeout}, 32'd1);
        chk_flush("t4_still_hold", 1'b1, 1'b1, 1'b1);
        tick();
        icache_busy = 1'b0;
        expect_load(n + 7, 32'h4000);
        tick();
        tick();
        sample();
        chk("t4_timeout_sticky", {31'd0, hold_timeout}, 32'd1);

        // 5: reset mid-HOLD
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_5000; icache_busy = 1'b1;
        tick();
        redirect_valid = 1'b0;
        sample();
        chk("t5_in_hold", {31'd0, redirect_busy}, 32'd1);
        tick();
        RESET = 1'b0;
        sample();
        chk_flush("t5_reset", 1'b0, 1'b0, 1'b0);
        chk("t5_reset_target", pc_target, 32'h0);
        chk("t5_reset_timeout", {31'd0, hold_timeout}, 32'd0);
        chk("t5_reset_pc_load", {31'd0, pc_load}, 32'd0);
        tick();
        RESET = 1'b1;
        icache_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t5_after_busy", {31'd0, redirect_busy}, 32'd0);
            tick();
        end

        // 6: misaligned target
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102; icache_busy = 1'b0;
        n = cyc;
`ifndef MISALIGN_TRAP_EN
        expect_load(n + 1, 32'h100);
`endif
        sample();
        chk_flush("t6_accept", 1'b1, 1'b1, 1'b0);
        tick();
        redirect_valid = 1'b0;
        sample();
`ifdef MISALIGN_TRAP_EN
        chk("t6_trap", {31'd0, misalign_trap}, 32'd1);
        chk("t6_busy", {31'd0, redirect_busy}, 32'd0);
`else
        chk("t6_no_trap", {31'd0, misalign_trap}, 32'd0);
        chk("t6_busy", {31'd0, redirect_busy}, 32'd1);
`endif
        tick();
        sample();
        chk("t6_trap_clear", {31'd0, misalign_trap}, 32'd0);

        for (int i = 0; i < 4; i++) tick();
        sample();
        chk("sb_drained", exp_cyc.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
